// File: rtl/imem_if.sv
// Bus bundle for the dual-port word memory: mode, address and write data for
// both ports, plus the registered read data and the address-error flag.
interface imem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              mem_rd;
  logic [ADDR_W-1:0] data;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] op1;
  logic              mem_rd1;
  logic [ADDR_W-1:0] data1;
  logic [DATA_W-1:0] wr_data1;
  logic [DATA_W-1:0] op2;
  logic              cout;

  modport master (
    output mem_rd, data, wr_data, mem_rd1, data1, wr_data1,
    input  op1, op2, cout
  );

  modport slave (
    input  mem_rd, data, wr_data, mem_rd1, data1, wr_data1,
    output op1, op2, cout
  );
endinterface

// File: rtl/imem.sv
// Dual-port synchronous word memory, read-first across ports, port 0 wins
// on same-address writes, out-of-range accesses flagged on cout.
module imem_port #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 128,
  parameter int IDX_W  = 7
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              oob_o,
  output logic [IDX_W-1:0]  idx_o
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  assign oob_o = {1'b0, addr_i} >= DEPTH_L;
  assign idx_o = addr_i[IDX_W-1:0];
endmodule

module imem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 128
) (
  input logic   clk,
  input logic   rst_n,
  imem_if.slave bus
);
  localparam int NPORT = 2;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NPORT-1:0]             rd;
  logic [NPORT-1:0][ADDR_W-1:0] addr;
  logic [NPORT-1:0][DATA_W-1:0] wdat;
  logic [NPORT-1:0]             oob;
  logic [NPORT-1:0][IDX_W-1:0]  idx;

  assign rd   = {bus.mem_rd1, bus.mem_rd};
  assign addr = {bus.data1, bus.data};
  assign wdat = {bus.wr_data1, bus.wr_data};

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    imem_port #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_port (
      .addr_i (addr[p]),
      .oob_o  (oob[p]),
      .idx_o  (idx[p])
    );
  end

  logic [DATA_W-1:0]            mem_q [DEPTH];
  logic [NPORT-1:0][DATA_W-1:0] op_q, op_d;
  logic                         cout_q, cout_d;

  // Reads see mem_q before this edge's writes, giving read-first behaviour.
  always_comb begin
    op_d   = op_q;
    cout_d = |oob;
    for (int p = 0; p < NPORT; p++) begin
      if (rd[p]) op_d[p] = oob[p] ? '0 : mem_q[idx[p]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      op_q   <= '0;
      cout_q <= 1'b0;
    end else begin
      op_q   <= op_d;
      cout_q <= cout_d;
      // Highest port first so port 0's assignment lands last and wins.
      for (int p = NPORT-1; p >= 0; p--) begin
        if (!rd[p] && !oob[p]) mem_q[idx[p]] <= wdat[p];
      end
    end
  end

  assign bus.op1  = op_q[0];
  assign bus.op2  = op_q[1];
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_imem.sv
// Directed bench for imem: reset, writes, range errors, collisions,
// read-first ordering and mid-run reset.
module tb_imem;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  imem_if #(.DATA_W(32), .ADDR_W(8)) bus ();

  imem #(.DATA_W(32), .ADDR_W(8), .DEPTH(128)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd0, input logic [7:0] a0, input logic [31:0] w0,
                       input logic rd1, input logic [7:0] a1, input logic [31:0] w1);
    bus.mem_rd  = rd0; bus.data  = a0; bus.wr_data  = w0;
    bus.mem_rd1 = rd1; bus.data1 = a1; bus.wr_data1 = w1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1, 8'd0, 32'h0, 1, 8'd0, 32'h0);
    cyc();
    chk("rst_op1", bus.op1, 32'h0);
    chk("rst_op2", bus.op2, 32'h0);
    chk("rst_cout", {31'b0, bus.cout}, 32'h0);
    rst_n = 1'b1;

    // Reset: read addr 0 on both ports
    cyc();
    chk("t1_op1", bus.op1, 32'h0);
    chk("t1_op2", bus.op2, 32'h0);
    chk("t1_cout", {31'b0, bus.cout}, 32'h0);

    // Write: port 0 mem[0]=1, port 1 mem[1]=5; op holds during writes
    drive(1, 8'd0, 32'h0, 1, 8'd0, 32'h0);
    drive(0, 8'd0, 32'h1, 0, 8'd1, 32'h5);
    cyc();
    chk("t2_hold_op1", bus.op1, 32'h0);
    chk("t2_wr_cout", {31'b0, bus.cout}, 32'h0);
    drive(1, 8'd0, 32'h0, 1, 8'd1, 32'h0);
    cyc();
    chk("t2_op1", bus.op1, 32'h1);
    chk("t2_op2", bus.op2, 32'h5);
    chk("t2_cout", {31'b0, bus.cout}, 32'h0);

    // Reset mid-operation during a write of 0x22 to addr 0
    rst_n = 1'b0;
    drive(0, 8'd0, 32'h22, 1, 8'd1, 32'h0);
    cyc();
    chk("t6_rst_op2", bus.op2, 32'h0);
    rst_n = 1'b1;
    drive(1, 8'd0, 32'h0, 1, 8'd1, 32'h0);
    cyc();
    chk("t6_op1", bus.op1, 32'h0);
    chk("t6_op2", bus.op2, 32'h0);

    // Out of range: seed mem[0]=0x33, then port 1 reads 128
    drive(0, 8'd0, 32'h33, 1, 8'd1, 32'h0);
    cyc();
    drive(1, 8'd0, 32'h0, 1, 8'd0, 32'h0);
    cyc();
    chk("t3_seed_op2", bus.op2, 32'h33);
    drive(1, 8'd0, 32'h0, 1, 8'd128, 32'h0);
    cyc();
    chk("t3_oob_op2", bus.op2, 32'h0);
    chk("t3_oob_op1", bus.op1, 32'h33);
    chk("t3_oob_cout", {31'b0, bus.cout}, 32'h1);
    drive(1, 8'd0, 32'h0, 0, 8'd200, 32'h7);
    cyc();
    chk("t3_wr200_cout", {31'b0, bus.cout}, 32'h1);
    // addr 200 aliases to 72 if the range check were ignored
    drive(1, 8'd0, 32'h0, 1, 8'd72, 32'h0);
    cyc();
    chk("t3_alias72", bus.op2, 32'h0);
    chk("t3_cout_clr", {31'b0, bus.cout}, 32'h0);
    drive(1, 8'd255, 32'h0, 1, 8'd0, 32'h0);
    cyc();
    chk("t3_p0oob_op1", bus.op1, 32'h0);
    chk("t3_p0oob_cout", {31'b0, bus.cout}, 32'h1);
    chk("t3_p0oob_op2", bus.op2, 32'h33);

    // Boundary: highest valid address 127
    drive(0, 8'd127, 32'hCAFE, 1, 8'd0, 32'h0);
    cyc();
    chk("b127_wr_cout", {31'b0, bus.cout}, 32'h0);
    drive(1, 8'd0, 32'h0, 1, 8'd127, 32'h0);
    cyc();
    chk("b127_op2", bus.op2, 32'hCAFE);
    chk("b127_cout", {31'b0, bus.cout}, 32'h0);

    // Collision: both ports write addr 3, port 0 wins
    drive(0, 8'd3, 32'hAAAA_0000, 0, 8'd3, 32'h5555_FFFF);
    cyc();
    drive(1, 8'd3, 32'h0, 1, 8'd3, 32'h0);
    cyc();
    chk("t4_op1", bus.op1, 32'hAAAA_0000);
    chk("t4_op2", bus.op2, 32'hAAAA_0000);

    // Read-first: port 0 writes, port 1 reads same address
    drive(0, 8'd4, 32'h9, 1, 8'd0, 32'h0);
    cyc();
    drive(0, 8'd4, 32'h11, 1, 8'd4, 32'h0);
    cyc();
    chk("t5_old_op2", bus.op2, 32'h9);
    drive(1, 8'd0, 32'h0, 1, 8'd4, 32'h0);
    cyc();
    chk("t5_new_op2", bus.op2, 32'h11);

    // Read-first in the other direction: port 1 writes, port 0 reads
    drive(1, 8'd5, 32'h0, 0, 8'd5, 32'h44);
    cyc();
    chk("t5b_old_op1", bus.op1, 32'h0);
    drive(1, 8'd5, 32'h0, 1, 8'd0, 32'h0);
    cyc();
    chk("t5b_new_op1", bus.op1, 32'h44);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
